// File: rtl/hazard_sequencer.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, branch redirects and
// data-memory freezes, with saturating perf counters and a sticky memory-timeout flag.
module hazard_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             mem_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_hold,
  output logic             exmem_flush,
  output logic             exmem_hold,
  output logic             mem_wait,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mem_timeout
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WaitW-1:0] WaitMax  = WaitW'(MEM_TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  localparam logic [0:0] StRun     = 1'b0;
  localparam logic [0:0] StMemWait = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic             load_use;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Priority: freeze > redirect > load-use stall > normal. Reset forces normal values.
  always_comb begin
    pc_write      = 1'b1;
    pc_sel_branch = 1'b0;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    idex_hold     = 1'b0;
    exmem_flush   = 1'b0;
    exmem_hold    = 1'b0;
    if (!reset) begin
      if (dmem_busy) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_hold  = 1'b1;
        exmem_hold = 1'b1;
      end else if (mem_branch_taken) begin
        pc_sel_branch = 1'b1;
        ifid_flush    = 1'b1;
        idex_bubble   = 1'b1;
        exmem_flush   = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = dmem_busy ? StMemWait : StRun;
    wait_cnt_d     = '0;
    if (dmem_busy) begin
      wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    mem_timeout_d  = mem_timeout_q || (dmem_busy && (wait_cnt_q == WaitLast));
    stall_cycles_d = stall_cycles_q;
    if (!pc_write && (stall_cycles_q != CntMax)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    flush_events_d = flush_events_q;
    if (pc_sel_branch && (flush_events_q != CntMax)) begin
      flush_events_d = flush_events_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StRun;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
      mem_timeout_q  <= mem_timeout_d;
    end
  end

  assign mem_wait     = (state_q == StMemWait);
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
  assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: a table of single-cycle control vectors plus
// hand-written freeze/redirect, timeout, saturation and mid-freeze reset sequences.
module tb_hazard_sequencer;

  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [4:0]      id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic            id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic            ex_mem_read = 1'b0, mem_branch_taken = 1'b0, dmem_busy = 1'b0;
  logic            pc_write, pc_sel_branch, ifid_write, ifid_flush;
  logic            idex_bubble, idex_hold, exmem_flush, exmem_hold, mem_wait, mem_timeout;
  logic [CntW-1:0] stall_cycles, flush_events;
  logic [7:0]      ctl;

  int errors = 0;
  int checks = 0;

  // {pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_bubble, idex_hold,
  //  exmem_flush, exmem_hold}
  localparam logic [7:0] Norm   = 8'b1010_0000;
  localparam logic [7:0] Stall  = 8'b0000_1000;
  localparam logic [7:0] Redir  = 8'b1111_1010;
  localparam logic [7:0] Freeze = 8'b0000_0101;

  hazard_sequencer #(
    .CNT_W      (CntW),
    .MEM_TIMEOUT(16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .mem_branch_taken(mem_branch_taken),
    .dmem_busy       (dmem_busy),
    .pc_write        (pc_write),
    .pc_sel_branch   (pc_sel_branch),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .idex_hold       (idex_hold),
    .exmem_flush     (exmem_flush),
    .exmem_hold      (exmem_hold),
    .mem_wait        (mem_wait),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
    .mem_timeout     (mem_timeout)
  );

  assign ctl = {pc_write, pc_sel_branch, ifid_write, ifid_flush,
                idex_bubble, idex_hold, exmem_flush, exmem_hold};

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] exrd;
    logic       mr;
    logic       br;
    logic       busy;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] exrd, input logic mr,
                        input logic br, input logic busy);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = exrd; ex_mem_read = mr; mem_branch_taken = br; dmem_busy = busy;
  endtask

  // Inputs change at negedge; comb outputs sampled 1ns later, well before the posedge.
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                      input logic u2, input logic [4:0] exrd, input logic mr,
                      input logic br, input logic busy);
    @(negedge clk);
    set_in(rs1, rs2, u1, u2, exrd, mr, br, busy);
    #1;
  endtask

  task automatic idle();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Norm};
    vecs[1] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, Stall};
    vecs[2] = '{5'd9, 5'd3, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, Stall};
    vecs[3] = '{5'd0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, Norm};
    vecs[4] = '{5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, Norm};
    vecs[5] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, Norm};
    vecs[6] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, Redir};
    vecs[7] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, Freeze};

    #1;
    check("reset_ctl", ctl, Norm);
    check("reset_stall", stall_cycles, 0);
    check("reset_flush", flush_events, 0);
    check("reset_mem_wait", mem_wait, 0);
    check("reset_timeout", mem_timeout, 0);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].exrd,
           vecs[i].mr, vecs[i].br, vecs[i].busy);
      check($sformatf("vec%0d_ctl", i), ctl, vecs[i].exp);
    end
    idle();
    check("table_stall", stall_cycles, 3);
    check("table_flush", flush_events, 1);

    // Load-use for one cycle, then the bubble clears the hazard.
    do_reset();
    step(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    check("lu_ctl", ctl, Stall);
    step(5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_after_ctl", ctl, Norm);
    idle();
    check("lu_stall", stall_cycles, 1);

    // x0 destination and unused operand never stall.
    do_reset();
    step(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("x0_ctl", ctl, Norm);
    step(5'd0, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    check("unused_ctl", ctl, Norm);
    idle();
    check("x0_stall", stall_cycles, 0);

    // Branch beats load-use.
    do_reset();
    step(5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    check("br_lu_ctl", ctl, Redir);
    idle();
    check("br_lu_flush", flush_events, 1);
    check("br_lu_stall", stall_cycles, 0);

    // Three frozen cycles with a taken branch in MEM, then redirect.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      check($sformatf("mw%0d_ctl", i), ctl, Freeze);
      check($sformatf("mw%0d_wait", i), mem_wait, (i >= 2) ? 1 : 0);
    end
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("mw4_ctl", ctl, Redir);
    check("mw4_wait", mem_wait, 1);
    idle();
    check("mw_wait_end", mem_wait, 0);
    check("mw_stall", stall_cycles, 3);
    check("mw_flush", flush_events, 1);

    // Timeout: 15-cycle burst stays clear, 16-cycle burst sets the sticky flag.
    do_reset();
    for (int i = 0; i < 15; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle();
    check("to15_flag", mem_timeout, 0);
    for (int i = 1; i <= 16; i++) begin
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      if (i == 16) check("to16_before_edge", mem_timeout, 0);
    end
    idle();
    check("to16_flag", mem_timeout, 1);
    repeat (3) idle();
    check("to_sticky", mem_timeout, 1);
    check("to_stall_sat", stall_cycles, 15);

    // Reset in the middle of a freeze returns everything to idle at once.
    for (int i = 0; i < 3; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("mid_wait_pre", mem_wait, 1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_ctl", ctl, Norm);
    check("mid_rst_wait", mem_wait, 0);
    check("mid_rst_stall", stall_cycles, 0);
    check("mid_rst_timeout", mem_timeout, 0);
    @(negedge clk);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Twenty load-use stalls saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) step(5'd0, 5'd6, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    idle();
    check("sat_stall", stall_cycles, 15);
    check("sat_flush", flush_events, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central stall/flush controller for the 5-stage pipelined processor.
- Drives the write-enable, hold, bubble and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards, squashes wrong-path instructions on a taken branch resolved in MEM, and freezes the whole pipe while data memory is busy.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- CNT_W, 16, width of the performance counters.
- MEM_TIMEOUT, 16, consecutive dmem_busy cycles that set mem_timeout (≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  reset: asynchronous, active-high.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  rd of the instruction in EX (ID/EX rd_out).
- ex_mem_read  in  1  EX instruction is a load.
- mem_branch_taken  in  1  branch in MEM resolved taken.
- dmem_busy  in  1  data memory cannot complete this cycle.
- pc_write  out  1  PC register enable.
- pc_sel_branch  out  1  PC mux selects branch target.
- ifid_write  out  1  IF/ID enable.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_bubble  out  1  ID/EX control fields load zero.
- idex_hold  out  1  ID/EX retains contents.
- exmem_flush  out  1  EX/MEM control fields load zero.
- exmem_hold  out  1  EX/MEM and MEM/WB retain contents.
- mem_wait  out  1  state == MEM_WAIT.
- stall_cycles  out  CNT_W  cycles with pc_write=0.
- flush_events  out  CNT_W  cycles with pc_sel_branch=1.
- mem_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (async): state=RUN; wait_cnt=0; stall_cycles=0; flush_events=0; mem_timeout=0. Combinational outputs take their RUN/no-hazard values: pc_write=1, ifid_write=1, all other control outputs 0.
- load_use = ex_mem_read & (ex_rd≠0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Control outputs are combinational from state and inputs, zero latency. Priority per cycle:
  1. dmem_busy=1 → FREEZE: pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1. No flush or bubble, even if mem_branch_taken or load_use.
  2. mem_branch_taken=1 → REDIRECT: pc_sel_branch=1, pc_write=1, ifid_flush=1, idex_bubble=1, exmem_flush=1. Squashes the 3 younger instructions. Overrides load_use.
  3. load_use=1 → STALL: pc_write=0, ifid_write=0, idex_bubble=1. Exactly one bubble: next cycle the bubble in EX has zero control, so the hazard clears.
  4. Otherwise → NORMAL: pc_write=1, ifid_write=1, rest 0.
- The branch instruction stays in MEM while frozen, because EX/MEM is held. The redirect therefore fires in the first cycle dmem_busy=0; no pending latch is kept.
- FSM:
  - RUN→MEM_WAIT when dmem_busy=1.
  - MEM_WAIT→RUN when dmem_busy=0. That same cycle is evaluated by priorities 2–4.
  - MEM_WAIT is used only for mem_wait and the timeout logic; output muxing depends on the inputs.
- wait_cnt (width clog2(MEM_TIMEOUT)+1): +1 each dmem_busy cycle, saturates at MEM_TIMEOUT; cleared on any dmem_busy=0 cycle.
- mem_timeout: set at the clock edge where dmem_busy=1 and wait_cnt==MEM_TIMEOUT-1. Visible the cycle after the MEM_TIMEOUT-th consecutive busy cycle. Cleared only by reset. Pipeline behaviour is unchanged by the flag.
- stall_cycles: +1 per edge with pc_write=0 (FREEZE or STALL). Saturates at 2^CNT_W-1.
- flush_events: +1 per edge with REDIRECT. Saturates likewise.
- Reset mid-freeze: all state clears immediately; outputs return to NORMAL asynchronously.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle pc_write=0, ifid_write=0, idex_bubble=1; then ex_mem_read=0 → NORMAL; stall_cycles=1.
- rd=x0 and unused operand: ex_rd=0 with matching id_rs1=0, and ex_rd=7 with id_rs2=7 but id_uses_rs2=0 → no stall, stall_cycles stays 0.
- Branch vs load-use: mem_branch_taken=1 together with load_use=1 → pc_sel_branch=1, ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=1; flush_events=1, stall_cycles=0.
- Memory wait with branch: dmem_busy=1 for 3 cycles with mem_branch_taken=1 throughout → 3 FREEZE cycles, mem_wait=1 from cycle 2; cycle 4 busy=0 → REDIRECT; stall_cycles=3, flush_events=1.
- Timeout: MEM_TIMEOUT=16, dmem_busy held 16 cycles → mem_timeout=1 after 16th edge; 15-cycle burst → stays 0; remains 1 after busy drops, cleared only by reset.
- Saturation/reset: CNT_W=4, 20 stall cycles → stall_cycles=15; assert reset during MEM_WAIT → state RUN, counters 0, pc_write=1 immediately.
